// File: rtl/sram_sp_init_array.sv
// Single-port SRAM with lane write mask that zero-fills every entry after reset.
// Reads return after READ_LAT cycles. Accesses are ignored until ready is high.
module sram_sp_init_array #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 200,
    parameter int LANES    = 2,
    parameter int READ_LAT = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    RW0_addr,
    input  logic             RW0_en,
    input  logic             RW0_wmode,
    input  logic [LANES-1:0] RW0_wmask,
    input  logic [WIDTH-1:0] RW0_wdata,
    output logic [WIDTH-1:0] RW0_rdata,
    output logic             RW0_rvalid,
    output logic             ready
);
    localparam int LW = WIDTH / LANES;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             pipe_vld_q, pipe_vld_d;
    logic [WIDTH-1:0] pipe_dat_q, pipe_dat_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] mem_array [DEPTH];

    logic             addr_ok;
    logic             rd_fire;
    logic [WIDTH-1:0] rd_dat;
    logic             src_vld;
    logic [WIDTH-1:0] src_dat;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [LANES-1:0] wr_lanes;
    logic [WIDTH-1:0] wr_dat;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign addr_ok = (int'(RW0_addr) < DEPTH);
    assign ready   = (state_q == ST_READY);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = cnt_q;
        wr_lanes = '0;
        wr_dat   = '0;
        case (state_q)
            ST_INIT: begin
                wr_en    = 1'b1;
                wr_lanes = '1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                wr_en    = RW0_en & RW0_wmode & addr_ok;
                wr_idx   = RW0_addr;
                wr_lanes = RW0_wmask;
                wr_dat   = RW0_wdata;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        rd_fire    = ready & RW0_en & ~RW0_wmode;
        rd_dat     = addr_ok ? mem_array[RW0_addr] : '0;
        pipe_vld_d = rd_fire;
        pipe_dat_d = rd_fire ? rd_dat : pipe_dat_q;
        src_vld    = (READ_LAT == 2) ? pipe_vld_q : rd_fire;
        src_dat    = (READ_LAT == 2) ? pipe_dat_q : rd_dat;
        rvalid_d   = src_vld;
        rdata_d    = src_vld ? src_dat : rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            pipe_vld_q <= 1'b0;
            pipe_dat_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_dat_q <= pipe_dat_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lanes[l]) begin
                    mem_array[wr_idx][l*LW +: LW] <= wr_dat[l*LW +: LW];
                end
            end
        end
    end

    assign RW0_rvalid = rvalid_q;
    assign RW0_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_sp_init_array.sv
// Drives three configurations (default, READ_LAT=2, DEPTH=5) with shared stimulus
// and checks ready/rvalid/rdata against a behavioural model and scoreboard.
module tb_sram_sp_init_array;
    localparam int W = 200;

    bit clock;
    always #5 clock = ~clock;

    logic          reset;
    logic          en;
    logic          wmode;
    logic [2:0]    addr;
    logic [1:0]    wmask;
    logic [W-1:0]  wdata;
    logic [2:0]    rvalid;
    logic [2:0]    ready;
    logic [2:0][W-1:0] rdata;

    sram_sp_init_array u0 (
        .clock(clock), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[0]),
        .RW0_rvalid(rvalid[0]), .ready(ready[0])
    );

    sram_sp_init_array #(.READ_LAT(2)) u1 (
        .clock(clock), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[1]),
        .RW0_rvalid(rvalid[1]), .ready(ready[1])
    );

    sram_sp_init_array #(.DEPTH(5)) u2 (
        .clock(clock), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[2]),
        .RW0_rvalid(rvalid[2]), .ready(ready[2])
    );

    typedef struct {
        int         inst;
        int         due;
        logic [W-1:0] dat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mdl8 [8];
    logic [W-1:0] mdl5 [5];
    logic [W-1:0] last [3];
    int           cnt8, cnt5, cyc;
    int           errors, checks;
    logic         hit;
    logic [W-1:0] exp_dat;
    logic [W-1:0] d1, d2, ones;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Applies one cycle of stimulus and advances the model across that edge.
    task automatic step(input logic rst, input logic e, input logic wm, input logic [2:0] a,
                        input logic [1:0] m, input logic [W-1:0] d);
        logic [W-1:0] rd;
        reset = rst; en = e; wmode = wm; addr = a; wmask = m; wdata = d;
        @(posedge clock);
        cyc++;
        if (rst) begin
            cnt8 = 0;
            cnt5 = 0;
            sb.delete();
            for (int i = 0; i < 8; i++) mdl8[i] = '0;
            for (int i = 0; i < 5; i++) mdl5[i] = '0;
            for (int i = 0; i < 3; i++) last[i] = '0;
        end else begin
            if (cnt8 >= 8 && e) begin
                if (wm) begin
                    for (int l = 0; l < 2; l++)
                        if (m[l]) mdl8[a][l*100 +: 100] = d[l*100 +: 100];
                end else begin
                    sb.push_back('{0, cyc, mdl8[a]});
                    sb.push_back('{1, cyc + 1, mdl8[a]});
                end
            end
            if (cnt5 >= 5 && e) begin
                if (wm) begin
                    if (a < 5)
                        for (int l = 0; l < 2; l++)
                            if (m[l]) mdl5[a][l*100 +: 100] = d[l*100 +: 100];
                end else begin
                    rd = '0;
                    if (a < 5) rd = mdl5[a];
                    sb.push_back('{2, cyc, rd});
                end
            end
            if (cnt8 < 8) cnt8++;
            if (cnt5 < 5) cnt5++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, '0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b1, 1'b0, a, 2'b00, '0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [W-1:0] d);
        step(1'b0, 1'b1, 1'b1, a, m, d);
    endtask

    // Output monitor: compares every instance each cycle on the falling edge.
    initial forever begin
        @(negedge clock);
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                hit     = 1'b0;
                exp_dat = last[k];
                foreach (sb[i]) begin
                    if (sb[i].inst == k && sb[i].due == cyc) begin
                        hit     = 1'b1;
                        exp_dat = sb[i].dat;
                    end
                end
                check($sformatf("u%0d_ready@%0d", k, cyc), W'(ready[k]),
                      W'((k == 2) ? (cnt5 >= 5) : (cnt8 >= 8)));
                check($sformatf("u%0d_rvalid@%0d", k, cyc), W'(rvalid[k]), W'(hit));
                check($sformatf("u%0d_rdata@%0d", k, cyc), rdata[k], exp_dat);
                last[k] = exp_dat;
            end
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due <= cyc) sb.delete(i);
        end
    end

    initial begin
        ones = '1;
        for (int i = 0; i < 7; i++) begin
            d1 = {d1[W-33:0], 32'($urandom)};
            d2 = {d2[W-33:0], 32'($urandom)};
        end

        // Reset, then init with an ignored write on the fourth INIT cycle.
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, '0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, '0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, '0);
        idle(3);
        wr(3'd5, 2'b11, ones);
        idle(6);

        // Every entry reads zero after init; addresses 5..7 are out of range for u2.
        for (int a = 0; a < 8; a++) rd(3'(a));
        idle(2);

        // Lane-masked write merge.
        wr(3'd3, 2'b11, {100'hA, 100'hB});
        wr(3'd3, 2'b01, {100'hF, 100'hC});
        rd(3'd3);
        idle(2);

        // Back-to-back reads after distinct writes, then hold.
        wr(3'd1, 2'b11, d1);
        wr(3'd2, 2'b11, d2);
        rd(3'd1);
        rd(3'd2);
        rd(3'd1);
        idle(4);

        // Address 6 is beyond DEPTH for u2: write dropped, read returns zero.
        wr(3'd6, 2'b11, ones);
        rd(3'd6);
        for (int a = 0; a < 5; a++) rd(3'(a));
        idle(2);

        // Reset in READY with a read in flight, then a second reset mid-init.
        rd(3'd5);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, '0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, '0);
        idle(10);
        rd(3'd3);
        rd(3'd1);
        rd(3'd6);
        idle(3);

        check("scoreboard_drained", W'(sb.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
